// File: rtl/neuron_mac_serial.sv
// ---------------------------------------------------------------------------
// neuron_mac_serial
//
// Time-multiplexed fully-connected neuron. One signed activation is accepted
// per cycle and multiply-accumulated against a runtime-loadable weight bank
// through a single multiplier. After N_IN beats the biased sum is shifted,
// optionally rectified, saturated and presented on a valid/ready output.
//
// Optional feature macro: NEURON_RELU_EN
//   defined   : negative sums give 0, positive sums saturate high only
//   undefined : linear output with signed two-sided saturation
//
// Ports
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   w_we     in   weight/bias write strobe (honoured in IDLE only)
//   w_addr   in   0..N_IN-1 selects a weight, N_IN selects the bias
//   w_data   in   signed weight/bias value
//   a_valid  in   activation beat valid
//   a_ready  out  activation beat accepted when a_valid & a_ready
//   a_data   in   signed activation
//   y_valid  out  result valid
//   y_ready  in   result consumed when y_valid & y_ready
//   y_data   out  signed result
//   busy     out  high in every state except IDLE
// ---------------------------------------------------------------------------
module neuron_mac_serial #(
  parameter int N_IN  = 15,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        w_we,
  input  logic [$clog2(N_IN+1)-1:0]   w_addr,
  input  logic signed [WW-1:0]        w_data,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic signed [DW-1:0]        a_data,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic signed [OUT_W-1:0]     y_data,
  output logic                        busy
);

  localparam int AW = $clog2(N_IN + 1);
  localparam int PW = DW + WW;
  // Width wide enough to hold both the accumulator and the output range with
  // a spare sign bit, so the clamp compares never wrap.
  localparam int EW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic [AW-1:0] LAST_IDX  = AW'(N_IN - 1);
  localparam logic [AW-1:0] BIAS_ADDR = AW'(N_IN);

  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [EW-1:0] OUT_MAX_E = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] OUT_MIN_E = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_RND   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Entries 0..N_IN-1 are weights, entry N_IN is the bias.
  logic signed [WW-1:0]    r_wmem [0:N_IN];

  logic signed [ACC_W-1:0] r_acc_p0;
  logic [AW-1:0]           r_idx_p0;
  logic                    r_y_valid_p1;
  logic signed [OUT_W-1:0] r_y_data_p1;

  logic                    w_a_ready;
  logic                    w_fire;
  logic signed [WW-1:0]    w_coef;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_shifted;

  // Floor shift of the accumulator (arithmetic on a signed operand).
  function automatic logic signed [ACC_W-1:0] shift_floor(input logic signed [ACC_W-1:0] acc);
    shift_floor = acc >>> SHIFT;
  endfunction

  // Optional ReLU on the true sign bit, then clamp to the OUT_W range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] s);
    logic signed [EW-1:0]    s_e;
    logic signed [OUT_W-1:0] res;
    s_e = {{(EW-ACC_W){s[ACC_W-1]}}, s};
    if (s_e > OUT_MAX_E)      res = OUT_MAX;
    else if (s_e < OUT_MIN_E) res = OUT_MIN;
    else                      res = s_e[OUT_W-1:0];
`ifdef NEURON_RELU_EN
    if (s[ACC_W-1]) res = '0;
`endif
    sat_out = res;
  endfunction

  assign w_coef     = r_wmem[r_idx_p0];
  assign w_prod     = a_data * w_coef;
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-WW){r_wmem[N_IN][WW-1]}}, r_wmem[N_IN]};
  assign w_shifted  = shift_floor(r_acc_p0);
  assign w_fire     = a_valid & w_a_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A pending weight write takes priority over an incoming beat.
        w_a_ready = !w_we;
        if (a_valid && !w_we) w_state_nxt = (N_IN == 1) ? S_RND : S_ACCUM;
      end
      S_ACCUM: begin
        w_a_ready = 1'b1;
        if (a_valid && (r_idx_p0 == LAST_IDX)) w_state_nxt = S_RND;
      end
      S_RND:   w_state_nxt = S_OUT;
      S_OUT:   if (y_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Weight bank: writable only while idle so a running sum never sees a change.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= N_IN; i++) r_wmem[i] <= '0;
    end else if ((r_state == S_IDLE) && w_we && (w_addr <= BIAS_ADDR)) begin
      r_wmem[w_addr] <= w_data;
    end
  end

  // ---- stage p0: serial multiply-accumulate --------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_p0 <= '0;
      r_idx_p0 <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_fire) begin
          r_acc_p0 <= w_bias_ext + w_prod_ext;
          r_idx_p0 <= AW'(1);
        end
        S_ACCUM: if (w_fire) begin
          r_acc_p0 <= r_acc_p0 + w_prod_ext;
          r_idx_p0 <= r_idx_p0 + 1'b1;
        end
        S_OUT: if (y_ready) begin
          r_acc_p0 <= '0;
          r_idx_p0 <= '0;
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: shift / ReLU / saturate and hold for the consumer ---------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y_valid_p1 <= 1'b0;
      r_y_data_p1  <= '0;
    end else if (r_state == S_RND) begin
      r_y_valid_p1 <= 1'b1;
      r_y_data_p1  <= sat_out(w_shifted);
    end else if ((r_state == S_OUT) && y_ready) begin
      r_y_valid_p1 <= 1'b0;
    end
  end

  assign a_ready = w_a_ready;
  assign y_valid = r_y_valid_p1;
  assign y_data  = r_y_data_p1;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_neuron_mac_serial.sv
// Directed bench for neuron_mac_serial. A second instance with SHIFT=4 shares
// all inputs and runs in lockstep so the shifted results can be checked too.
module tb_neuron_mac_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              w_we;
  logic [3:0]        w_addr;
  logic signed [7:0] w_data;
  logic              a_valid;
  logic signed [7:0] a_data;
  logic              y_ready;

  logic               a_ready, y_valid, busy;
  logic signed [15:0] y_data;
  logic               a_ready_s4, y_valid_s4, busy_s4;
  logic signed [15:0] y_data_s4;

  int errs   = 0;
  int checks = 0;

  neuron_mac_serial #(.N_IN(15), .DW(8), .WW(8), .ACC_W(24), .OUT_W(16), .SHIFT(0)) u_dut (
    .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .busy(busy)
  );

  neuron_mac_serial #(.N_IN(15), .DW(8), .WW(8), .ACC_W(24), .OUT_W(16), .SHIFT(4)) u_dut_s4 (
    .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready_s4), .a_data(a_data),
    .y_valid(y_valid_s4), .y_ready(y_ready), .y_data(y_data_s4), .busy(busy_s4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int addr, input logic signed [7:0] d);
    w_we   = 1'b1;
    w_addr = 4'(addr);
    w_data = d;
    tick();
    w_we   = 1'b0;
  endtask

  task automatic load_all(input logic signed [7:0] w, input logic signed [7:0] b);
    for (int i = 0; i < 15; i++) write_w(i, w);
    write_w(15, b);
  endtask

  task automatic send_beats(input int n, input logic signed [7:0] a);
    for (int i = 0; i < n; i++) begin
      a_valid = 1'b1;
      a_data  = a;
      tick();
    end
    a_valid = 1'b0;
  endtask

  task automatic wait_y();
    for (int i = 0; i < 10 && !y_valid; i++) tick();
  endtask

  task automatic pop();
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (y_valid !== 1'b0) begin errs++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
    checks++; if (y_data !== 16'sd0) begin errs++; $display("FAIL reset_y_data: got %0d expected 0", y_data); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (a_ready !== 1'b1) begin errs++; $display("FAIL reset_a_ready: got %b expected 1", a_ready); end
  endtask

  task automatic test_basic_sum();
    load_all(8'sd1, 8'sd0);
    send_beats(15, 8'sd1);
    // One edge after the last beat the block is in RND: no result yet.
    checks++; if (y_valid !== 1'b0) begin errs++; $display("FAIL latency_early: y_valid got %b expected 0", y_valid); end
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL latency_busy: got %b expected 1", busy); end
    tick();
    checks++; if (y_valid !== 1'b1) begin errs++; $display("FAIL latency_valid: y_valid got %b expected 1", y_valid); end
    checks++; if (y_data !== 16'sd15) begin errs++; $display("FAIL basic_sum: got %0d expected 15", y_data); end
    pop();
    checks++; if (y_valid !== 1'b0) begin errs++; $display("FAIL pop_clears_valid: got %b expected 0", y_valid); end
    write_w(15, -8'sd2);
    send_beats(15, 8'sd1);
    wait_y();
    checks++; if (y_valid !== 1'b1) begin errs++; $display("FAIL bias_timeout: y_valid got %b expected 1", y_valid); end
    checks++; if (y_data !== 16'sd13) begin errs++; $display("FAIL bias_sum: got %0d expected 13", y_data); end
    pop();
  endtask

  task automatic test_negative();
    logic signed [15:0] exp0, exp4;
`ifdef NEURON_RELU_EN
    exp0 = 16'sd0;
    exp4 = 16'sd0;
`else
    exp0 = 16'sh8000;     // -32768
    exp4 = -16'sd15240;   // -243840 >>> 4
`endif
    load_all(-8'sd128, 8'sd0);
    send_beats(15, 8'sd127);
    wait_y();
    checks++; if (y_valid !== 1'b1) begin errs++; $display("FAIL neg_timeout: y_valid got %b expected 1", y_valid); end
    checks++; if (y_data !== exp0) begin errs++; $display("FAIL neg_sat: got %0d expected %0d", y_data, exp0); end
    checks++; if (y_data_s4 !== exp4) begin errs++; $display("FAIL neg_shift4: got %0d expected %0d", y_data_s4, exp4); end
    pop();
  endtask

  task automatic test_pos_sat();
    load_all(8'sd127, 8'sd0);
    send_beats(15, 8'sd127);
    wait_y();
    checks++; if (y_valid !== 1'b1) begin errs++; $display("FAIL pos_timeout: y_valid got %b expected 1", y_valid); end
    checks++; if (y_data !== 16'sd32767) begin errs++; $display("FAIL pos_sat: got %0d expected 32767", y_data); end
    checks++; if (y_data_s4 !== 16'sd15120) begin errs++; $display("FAIL pos_shift4: got %0d expected 15120", y_data_s4); end
    pop();
  endtask

  task automatic test_backpressure();
    // Weights are still 127, bias 0: 15 beats of 1 give 1905.
    send_beats(15, 8'sd1);
    wait_y();
    for (int c = 0; c < 5; c++) begin
      a_valid = 1'b1;
      a_data  = 8'sd5;
      checks++; if (y_valid !== 1'b1) begin errs++; $display("FAIL stall_valid[%0d]: got %b expected 1", c, y_valid); end
      checks++; if (y_data !== 16'sd1905) begin errs++; $display("FAIL stall_data[%0d]: got %0d expected 1905", c, y_data); end
      checks++; if (a_ready !== 1'b0) begin errs++; $display("FAIL stall_a_ready[%0d]: got %b expected 0", c, a_ready); end
      tick();
    end
    a_valid = 1'b0;
    pop();
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL stall_release_busy: got %b expected 0", busy); end
    send_beats(15, 8'sd1);
    wait_y();
    checks++; if (y_data !== 16'sd1905) begin errs++; $display("FAIL after_stall: got %0d expected 1905", y_data); end
    pop();
  endtask

  task automatic test_back_to_back();
    int first, second, npulse;
    first = -1; second = -1; npulse = 0;
    a_valid = 1'b1;
    a_data  = 8'sd2;
    y_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (y_valid) begin
        npulse++;
        if (first < 0) first = c; else if (second < 0) second = c;
        checks++; if (y_data !== 16'sd3810) begin errs++; $display("FAIL b2b_data@%0d: got %0d expected 3810", c, y_data); end
      end
    end
    a_valid = 1'b0;
    y_ready = 1'b0;
    checks++; if (npulse !== 2) begin errs++; $display("FAIL b2b_pulses: got %0d expected 2", npulse); end
    checks++; if (second - first !== 17) begin errs++; $display("FAIL b2b_period: got %0d expected 17", second - first); end
  endtask

  task automatic test_reset_midstream();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_all(8'sd1, 8'sd0);
    send_beats(7, 8'sd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (y_valid !== 1'b0) begin errs++; $display("FAIL midrst_y_valid: got %b expected 0", y_valid); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (a_ready !== 1'b1) begin errs++; $display("FAIL midrst_a_ready: got %b expected 1", a_ready); end
    send_beats(15, 8'sd3);
    wait_y();
    checks++; if (y_valid !== 1'b1) begin errs++; $display("FAIL midrst_timeout: y_valid got %b expected 1", y_valid); end
    checks++; if (y_data !== 16'sd0) begin errs++; $display("FAIL midrst_cleared_weights: got %0d expected 0", y_data); end
    pop();
  endtask

  task automatic test_write_rules();
    for (int i = 0; i < 15; i++) write_w(i, 8'(i + 1));
    write_w(15, 8'sd0);
    send_beats(3, 8'sd1);
    // Write attempt while accumulating: must be dropped.
    w_we = 1'b1; w_addr = 4'd10; w_data = 8'sd50;
    a_valid = 1'b1; a_data = 8'sd1;
    tick();
    w_we = 1'b0;
    send_beats(11, 8'sd1);
    wait_y();
    checks++; if (y_data !== 16'sd120) begin errs++; $display("FAIL accum_write_ignored: got %0d expected 120", y_data); end
    pop();
    // Write and beat together in IDLE: write wins, beat taken next cycle.
    w_we = 1'b1; w_addr = 4'd0; w_data = 8'sd20;
    a_valid = 1'b1; a_data = 8'sd1;
    #1;
    checks++; if (a_ready !== 1'b0) begin errs++; $display("FAIL idle_write_a_ready: got %b expected 0", a_ready); end
    tick();
    w_we = 1'b0;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_write_beat_taken: busy got %b expected 0", busy); end
    send_beats(15, 8'sd1);
    wait_y();
    checks++; if (y_data !== 16'sd139) begin errs++; $display("FAIL idle_write_applied: got %0d expected 139", y_data); end
    pop();
  endtask

  initial begin
    reset   = 1'b1;
    w_we    = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    a_valid = 1'b0;
    a_data  = '0;
    y_ready = 1'b0;
    test_reset();
    test_basic_sum();
    test_negative();
    test_pos_sat();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_write_rules();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
